// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_mod_counter
// Description : Modulo-MOD_VAL up/down counter with enable, clamped parallel
//               load and wrap / saturate / one-shot terminal-count modes.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MOD_VAL = 16,
    parameter int RST_VAL = MOD_VAL - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    localparam logic [WIDTH-1:0] c_max_val = WIDTH'(MOD_VAL - 1);
    localparam logic [WIDTH-1:0] c_rst_val = WIDTH'(RST_VAL);
    localparam logic [1:0]       c_mode_sat   = 2'b01;
    localparam logic [1:0]       c_mode_oneshot = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_terminal;
    logic             w_at_term;
    logic             w_load_ovf;

    assign w_terminal = up_dn ? c_max_val : '0;
    assign w_at_term  = (r_count == w_terminal);
    // One extra bit so the clamp compare also works when MOD_VAL == 2**WIDTH.
    assign w_load_ovf = ({1'b0, load_val} > {1'b0, c_max_val});

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        w_done_nxt  = r_done;
        if (load) begin
            w_count_nxt = w_load_ovf ? c_max_val : load_val;
            w_done_nxt  = 1'b0;
            w_state_nxt = ST_RUN;
        end else if (en && (r_state == ST_RUN)) begin
            if (!w_at_term) begin
                w_count_nxt = up_dn ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
            end else begin
                case (mode)
                    c_mode_sat: begin
                        w_count_nxt = r_count;
                    end
                    c_mode_oneshot: begin
                        w_state_nxt = ST_HALT;
                        w_done_nxt  = 1'b1;
                    end
                    default: begin
                        w_count_nxt = up_dn ? '0 : c_max_val;
                        w_wrap_nxt  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_count <= c_rst_val;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign count = r_count;
    assign tc    = w_at_term;
    assign wrap  = r_wrap;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_mod_counter
// Description : Directed bench for updown_mod_counter (MOD 16 and MOD 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, wrap_a, wrap_b, done_a, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    updown_mod_counter #(.WIDTH(4), .MOD_VAL(16)) u_dut_a (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
        .load(load), .load_val(load_val),
        .count(count_a), .tc(tc_a), .wrap(wrap_a), .done(done_a)
    );

    updown_mod_counter #(.WIDTH(4), .MOD_VAL(10), .RST_VAL(9)) u_dut_b (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .mode(mode),
        .load(load), .load_val(load_val),
        .count(count_b), .tc(tc_b), .wrap(wrap_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b1; up_dn = 1'b0; mode = 2'b00; load = 1'b0; load_val = 4'd0;
        tick; tick;
        n_cmp++; if (count_a !== 4'd15) begin n_bad++; $display("FAIL reset_count: got %0d want 15", count_a); end
        n_cmp++; if (wrap_a !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_cmp++; if (count_b !== 4'd9) begin n_bad++; $display("FAIL reset_count_mod10: got %0d want 9", count_b); end
        n_cmp++; if (tc_a !== 1'b0) begin n_bad++; $display("FAIL reset_tc_down: got %b want 0", tc_a); end
        rst = 1'b0;
        tick;
        n_cmp++; if (count_a !== 4'd14) begin n_bad++; $display("FAIL down_step1: got %0d want 14", count_a); end
        tick;
        n_cmp++; if (count_a !== 4'd13) begin n_bad++; $display("FAIL down_step2: got %0d want 13", count_a); end
        tick;
        n_cmp++; if (count_a !== 4'd12) begin n_bad++; $display("FAIL down_step3: got %0d want 12", count_a); end
    endtask

    task automatic test_down_wrap;
        en = 1'b0; load = 1'b1; load_val = 4'd0; up_dn = 1'b0; mode = 2'b00;
        tick;
        load = 1'b0;
        n_cmp++; if (count_a !== 4'd0) begin n_bad++; $display("FAIL dwrap_load0: got %0d want 0", count_a); end
        n_cmp++; if (tc_a !== 1'b1) begin n_bad++; $display("FAIL dwrap_tc_at0: got %b want 1", tc_a); end
        en = 1'b1;
        tick;
        n_cmp++; if (count_a !== 4'd15) begin n_bad++; $display("FAIL dwrap_count: got %0d want 15", count_a); end
        n_cmp++; if (wrap_a !== 1'b1) begin n_bad++; $display("FAIL dwrap_pulse: got %b want 1", wrap_a); end
        tick;
        n_cmp++; if (count_a !== 4'd14) begin n_bad++; $display("FAIL dwrap_after: got %0d want 14", count_a); end
        n_cmp++; if (wrap_a !== 1'b0) begin n_bad++; $display("FAIL dwrap_pulse_end: got %b want 0", wrap_a); end
    endtask

    task automatic test_mod10;
        en = 1'b0; up_dn = 1'b1; mode = 2'b00; load = 1'b1; load_val = 4'd7;
        tick;
        load = 1'b0; en = 1'b1;
        n_cmp++; if (count_b !== 4'd7) begin n_bad++; $display("FAIL m10_load7: got %0d want 7", count_b); end
        tick;
        n_cmp++; if (count_b !== 4'd8) begin n_bad++; $display("FAIL m10_step8: got %0d want 8", count_b); end
        tick;
        n_cmp++; if (count_b !== 4'd9) begin n_bad++; $display("FAIL m10_step9: got %0d want 9", count_b); end
        n_cmp++; if (tc_b !== 1'b1) begin n_bad++; $display("FAIL m10_tc9: got %b want 1", tc_b); end
        n_cmp++; if (wrap_b !== 1'b0) begin n_bad++; $display("FAIL m10_nowrap9: got %b want 0", wrap_b); end
        tick;
        n_cmp++; if (count_b !== 4'd0) begin n_bad++; $display("FAIL m10_wrap0: got %0d want 0", count_b); end
        n_cmp++; if (wrap_b !== 1'b1) begin n_bad++; $display("FAIL m10_wrap_pulse: got %b want 1", wrap_b); end
        tick;
        n_cmp++; if (count_b !== 4'd1) begin n_bad++; $display("FAIL m10_step1: got %0d want 1", count_b); end
        n_cmp++; if (wrap_b !== 1'b0) begin n_bad++; $display("FAIL m10_wrap_end: got %b want 0", wrap_b); end
        en = 1'b0; load = 1'b1; load_val = 4'd12;
        tick;
        load = 1'b0;
        n_cmp++; if (count_b !== 4'd9) begin n_bad++; $display("FAIL m10_load12_clamp: got %0d want 9", count_b); end
        n_cmp++; if (count_a !== 4'd12) begin n_bad++; $display("FAIL m16_load12: got %0d want 12", count_a); end
    endtask

    task automatic test_saturate;
        en = 1'b0; up_dn = 1'b1; mode = 2'b01; load = 1'b1; load_val = 4'd14;
        tick;
        load = 1'b0; en = 1'b1;
        n_cmp++; if (count_a !== 4'd14) begin n_bad++; $display("FAIL sat_load14: got %0d want 14", count_a); end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_cmp++; if (count_a !== 4'd15 || wrap_a !== 1'b0 || tc_a !== 1'b1) begin
                n_bad++; $display("FAIL sat_hold%0d: got count=%0d wrap=%b tc=%b want 15/0/1", i, count_a, wrap_a, tc_a);
            end
        end
        up_dn = 1'b0;
        #1;
        n_cmp++; if (tc_a !== 1'b0) begin n_bad++; $display("FAIL sat_tc_flip: got %b want 0", tc_a); end
        tick;
        n_cmp++; if (count_a !== 4'd14) begin n_bad++; $display("FAIL sat_step_down: got %0d want 14", count_a); end
    endtask

    task automatic test_oneshot;
        en = 1'b0; up_dn = 1'b0; mode = 2'b10; load = 1'b1; load_val = 4'd3;
        tick;
        load = 1'b0; en = 1'b1;
        tick;
        n_cmp++; if (count_a !== 4'd2 || done_a !== 1'b0) begin n_bad++; $display("FAIL os_step2: got count=%0d done=%b want 2/0", count_a, done_a); end
        tick;
        n_cmp++; if (count_a !== 4'd1) begin n_bad++; $display("FAIL os_step1: got %0d want 1", count_a); end
        tick;
        n_cmp++; if (count_a !== 4'd0) begin n_bad++; $display("FAIL os_step0: got %0d want 0", count_a); end
        tick;
        n_cmp++; if (count_a !== 4'd0 || done_a !== 1'b1) begin n_bad++; $display("FAIL os_halt: got count=%0d done=%b want 0/1", count_a, done_a); end
        en = 1'b0; tick;
        en = 1'b1; mode = 2'b00; tick;
        mode = 2'b01; tick;
        n_cmp++; if (count_a !== 4'd0 || done_a !== 1'b1 || wrap_a !== 1'b0) begin
            n_bad++; $display("FAIL os_stay_halt: got count=%0d done=%b wrap=%b want 0/1/0", count_a, done_a, wrap_a);
        end
        mode = 2'b10; load = 1'b1; load_val = 4'd5;
        tick;
        load = 1'b0;
        n_cmp++; if (count_a !== 4'd5 || done_a !== 1'b0) begin n_bad++; $display("FAIL os_reload: got count=%0d done=%b want 5/0", count_a, done_a); end
        tick;
        n_cmp++; if (count_a !== 4'd4) begin n_bad++; $display("FAIL os_resume: got %0d want 4", count_a); end
    endtask

    task automatic test_simultaneous;
        rst = 1'b1; load = 1'b1; load_val = 4'd3; en = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if (count_a !== 4'd15) begin n_bad++; $display("FAIL sim_rst_over_load: got %0d want 15", count_a); end
        load = 1'b1; load_val = 4'd6; up_dn = 1'b1; mode = 2'b00;
        tick;
        load = 1'b0;
        n_cmp++; if (count_a !== 4'd6) begin n_bad++; $display("FAIL sim_load_over_en: got %0d want 6", count_a); end
        tick;
        n_cmp++; if (count_a !== 4'd7) begin n_bad++; $display("FAIL sim_step_after_load: got %0d want 7", count_a); end
        mode = 2'b10; up_dn = 1'b0; load = 1'b1; load_val = 4'd1;
        tick;
        load = 1'b0;
        tick; tick;
        n_cmp++; if (done_a !== 1'b1 || count_a !== 4'd0) begin n_bad++; $display("FAIL sim_enter_halt: got count=%0d done=%b want 0/1", count_a, done_a); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_cmp++; if (count_a !== 4'd15 || done_a !== 1'b0) begin n_bad++; $display("FAIL sim_rst_halt: got count=%0d done=%b want 15/0", count_a, done_a); end
        tick;
        n_cmp++; if (count_a !== 4'd14) begin n_bad++; $display("FAIL sim_run_after_rst: got %0d want 14", count_a); end
    endtask

    initial begin
        test_reset;
        test_down_wrap;
        test_mod10;
        test_saturate;
        test_oneshot;
        test_simultaneous;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
